// File: rtl/key_conditioner.sv
// key_conditioner: per-key 2-FF synchronizer, counter-based debounce and
// registered single-cycle press/release pulses for board push-buttons.
// Optional feature macro: AUTOREPEAT_EN adds hold-to-repeat press pulses
// (first after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
// KEY0 is a synchronous active-high reset.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              KEY0,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Polarity normalised once so everything downstream is active-high.
  logic [N_KEYS-1:0] pressed;
  assign pressed = key_raw ^ {N_KEYS{ACTIVE_LOW}};

  logic [N_KEYS-1:0]            sync1;
  logic [N_KEYS-1:0]            sync2;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt;
  logic [N_KEYS-1:0][CNT_W-1:0] cnt_nxt;
  logic [N_KEYS-1:0]            accept;
  logic [N_KEYS-1:0]            rpt_hit;

  // Debounce decision: count consecutive samples that disagree with the
  // accepted level; any agreeing sample restarts the count.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i]  = 1'b0;
      cnt_nxt[i] = '0;
      if (sync2[i] == key_level[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        accept[i]  = 1'b1;
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);

  logic [N_KEYS-1:0][RPT_W-1:0] rpt_cnt;
  logic [N_KEYS-1:0][RPT_W-1:0] rpt_cnt_nxt;
  logic [N_KEYS-1:0]            rpt_started;
  logic [N_KEYS-1:0]            rpt_started_nxt;

  // Hold-to-repeat timing: the counter only runs while the key is held and
  // no release is being accepted this cycle, so a release never repeats.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      rpt_hit[i]         = 1'b0;
      rpt_cnt_nxt[i]     = rpt_cnt[i];
      rpt_started_nxt[i] = rpt_started[i];
      if (!key_level[i] || accept[i]) begin
        rpt_cnt_nxt[i]     = '0;
        rpt_started_nxt[i] = 1'b0;
      end else if (rpt_cnt[i] == (rpt_started[i] ? RPT_NEXT : RPT_FIRST)) begin
        rpt_hit[i]         = 1'b1;
        rpt_cnt_nxt[i]     = '0;
        rpt_started_nxt[i] = 1'b1;
      end else begin
        rpt_cnt_nxt[i] = rpt_cnt[i] + RPT_ONE;
      end
    end
  end

  // Repeat counter state.
  always_ff @(posedge clk) begin
    if (KEY0) begin
      rpt_cnt     <= '0;
      rpt_started <= '0;
    end else begin
      rpt_cnt     <= rpt_cnt_nxt;
      rpt_started <= rpt_started_nxt;
    end
  end
`else
  // Repeat feature absent: no extra press pulses.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY != REPEAT_PERIOD);
  assign rpt_hit = '0;
`endif

  // Synchronizer, debounce state and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (KEY0) begin
      sync1       <= '0;
      sync2       <= '0;
      cnt         <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      sync1       <= pressed;
      sync2       <= sync1;
      cnt         <= cnt_nxt;
      key_level   <= key_level ^ accept;
      key_press   <= (accept & sync2) | rpt_hit;
      key_release <= accept & ~sync2;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1,
// REPEAT_DELAY=10, REPEAT_PERIOD=3). Expected pulses are scheduled into a
// queue when stimulus is applied and compared every cycle.
module tb_key_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic       clk = 1'b0;
  logic       KEY0;
  logic [1:0] key_raw;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;

  typedef struct {
    int         cyc;
    logic [1:0] press;
    logic [1:0] rel;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   c0;
  int   p0;

  key_conditioner #(
    .N_KEYS(2),
    .DEBOUNCE_CYCLES(DEB),
    .ACTIVE_LOW(1'b1),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .KEY0(KEY0),
    .key_raw(key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, want);
    end
  endtask

  task automatic expect_at(input int at, input logic [1:0] p, input logic [1:0] r);
    exp_t e;
    e.cyc   = at;
    e.press = p;
    e.rel   = r;
    exp_q.push_back(e);
  endtask

  // One clock: advance, then compare pulse outputs against the schedule.
  task automatic step();
    logic [1:0] ep;
    logic [1:0] er;
    ep = 2'b00;
    er = 2'b00;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      if (exp_q[0].cyc == cyc) begin
        ep = ep | exp_q[0].press;
        er = er | exp_q[0].rel;
      end
      void'(exp_q.pop_front());
    end
    check_val("key_press", {30'd0, key_press}, {30'd0, ep});
    check_val("key_release", {30'd0, key_release}, {30'd0, er});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    // Reset with both keys held: outputs stay 0, then a fresh press on both.
    KEY0    = 1'b1;
    key_raw = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("rst_level", {30'd0, key_level}, 32'd0);
    end
    KEY0 = 1'b0;
    expect_at(cyc + DEB + 2, 2'b11, 2'b00);
    run(DEB + 1);
    check_val("rst_level_early", {30'd0, key_level}, 32'd0);
    step();
    check_val("rst_level_both", {30'd0, key_level}, 32'd3);
    run(3);
    key_raw = 2'b11;
    expect_at(cyc + DEB + 2, 2'b00, 2'b11);
    run(8);
    check_val("both_released", {30'd0, key_level}, 32'd0);

    // Clean press and release on key 0.
    key_raw = 2'b10;
    expect_at(cyc + DEB + 2, 2'b01, 2'b00);
    run(DEB + 2);
    check_val("clean_level", {30'd0, key_level}, 32'd1);
    run(4);
    key_raw = 2'b11;
    expect_at(cyc + DEB + 2, 2'b00, 2'b01);
    run(DEB + 2);
    check_val("clean_released", {30'd0, key_level}, 32'd0);
    run(3);

    // Bounce: 3 low, 1 high, then steady low -> one press only.
    c0 = cyc;
    key_raw = 2'b10;
    run(3);
    key_raw = 2'b11;
    run(1);
    key_raw = 2'b10;
    expect_at(c0 + 10, 2'b01, 2'b00);
    run(DEB + 2);
    check_val("bounce_level", {30'd0, key_level}, 32'd1);
    key_raw = 2'b11;
    expect_at(cyc + DEB + 2, 2'b00, 2'b01);
    run(8);

    // Reset after two mismatch cycles: progress discarded, full latency again.
    key_raw = 2'b10;
    run(4);
    KEY0 = 1'b1;
    run(1);
    check_val("midrst_level", {30'd0, key_level}, 32'd0);
    KEY0 = 1'b0;
    expect_at(cyc + DEB + 2, 2'b01, 2'b00);
    run(DEB + 2);
    check_val("midrst_press_level", {30'd0, key_level}, 32'd1);
    key_raw = 2'b11;
    expect_at(cyc + DEB + 2, 2'b00, 2'b01);
    run(8);

    // Long hold on key 1 (repeats only with AUTOREPEAT_EN).
    key_raw = 2'b01;
    p0 = cyc + DEB + 2;
    expect_at(p0, 2'b10, 2'b00);
`ifdef AUTOREPEAT_EN
    for (int k = 0; k < 5; k++) expect_at(p0 + RD + k * RP, 2'b10, 2'b00);
`endif
    run(DEB + 2);
    check_val("hold_level", {30'd0, key_level}, 32'd2);
    run(18);
    key_raw = 2'b11;
    expect_at(cyc + DEB + 2, 2'b00, 2'b10);
    run(10);
    check_val("hold_released", {30'd0, key_level}, 32'd0);

    // Simultaneous press and release on both keys.
    key_raw = 2'b00;
    expect_at(cyc + DEB + 2, 2'b11, 2'b00);
    run(DEB + 2);
    check_val("simul_level", {30'd0, key_level}, 32'd3);
    key_raw = 2'b11;
    expect_at(cyc + DEB + 2, 2'b00, 2'b11);
    run(8);

    check_val("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
